// File: rtl/interrupt_controller_pkg.sv
// Shared memory-map addresses, dispatch-vector constants and FSM state type
// for the interrupt controller.
package interrupt_controller_pkg;

    localparam logic [15:0] ADDR_IF    = 16'hFF0F;
    localparam logic [15:0] ADDR_IE    = 16'hFFFF;

    localparam logic [15:0] VEC_BASE   = 16'h0040;
    localparam logic [15:0] VEC_STRIDE = 16'h0008;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    function automatic logic [15:0] vector_of(input logic [2:0] idx);
        return VEC_BASE + VEC_STRIDE * 16'(idx);
    endfunction

endpackage

// File: rtl/interrupt_controller_int_priority_encoder.sv
// Fixed-priority selector: bit 0 highest, bit 4 lowest; outputs the winner
// as a one-hot mask and as a binary index.
module int_priority_encoder (
    input  logic [4:0] pending_i,
    output logic [4:0] onehot_o,
    output logic [2:0] index_o
);

    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        // Scan low-to-high priority so the lowest set bit is the last to win.
        for (int i = 4; i >= 0; i--) begin
            if (pending_i[i]) begin
                onehot_o = 5'(1) << i;
                index_o  = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE interrupt controller with edge- or level-triggered request capture
// and an IDLE/PENDING/SERVICE dispatch handshake toward the CPU.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic        I_CLOCK,
    input  logic        I_RESET_L,
    input  logic [15:0] I_ADDR,
    inout  wire  [7:0]  IO_DATA,
    input  logic        I_RE_L,
    input  logic        I_WE_L,
    input  logic        I_VBLANK_INT,
    input  logic        I_LCDC_INT,
    input  logic        I_TIMER_INT,
    input  logic        I_SERIAL_INT,
    input  logic        I_JOYPAD_INT,
    input  logic        I_INT_ACK,
    output logic        O_INT_REQ,
    output logic [15:0] O_INT_VECTOR,
    output logic [7:0]  O_IF_DATA,
    output logic [7:0]  O_IE_DATA
);

    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic [4:0]  prev_q;
    logic [15:0] vec_q, vec_d;
    logic        ack_block_q, ack_block_d;
    irq_state_e  state_q, state_d;

    logic [4:0]  src;
    logic [4:0]  set_mask, ack_mask, pending, win_onehot;
    logic [2:0]  win_index;
    logic        sel_if, sel_ie, if_we, ie_we, any_pending, ack_take;
    logic [7:0]  rd_data;

    assign src      = {I_JOYPAD_INT, I_SERIAL_INT, I_TIMER_INT, I_LCDC_INT, I_VBLANK_INT};
    assign sel_if   = (I_ADDR == ADDR_IF);
    assign sel_ie   = (I_ADDR == ADDR_IE);
    assign if_we    = ~I_WE_L & sel_if;
    assign ie_we    = ~I_WE_L & sel_ie;

    assign set_mask = (EDGE_MODE != 0) ? (src & ~prev_q) : src;
    assign pending  = if_q & ie_q[4:0];
    assign any_pending = |pending;

    int_priority_encoder u_prio (
        .pending_i (pending),
        .onehot_o  (win_onehot),
        .index_o   (win_index)
    );

    // An ack still held from before a reset must drop before it can dispatch again.
    assign ack_take = (state_q == ST_PENDING) & any_pending & I_INT_ACK & ~ack_block_q;
    assign ack_mask = ack_take ? win_onehot : 5'b0;

    assign if_d        = ((if_we ? IO_DATA[4:0] : if_q) & ~ack_mask) | set_mask;
    assign ie_d        = ie_we ? IO_DATA : ie_q;
    assign ack_block_d = ack_block_q & I_INT_ACK;

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        O_INT_REQ    = 1'b0;
        O_INT_VECTOR = 16'h0000;
        case (state_q)
            ST_IDLE: begin
                if (any_pending) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                O_INT_REQ    = any_pending;
                O_INT_VECTOR = any_pending ? vector_of(win_index) : 16'h0000;
                if (ack_take) begin
                    vec_d   = vector_of(win_index);
                    state_d = ST_SERVICE;
                end else if (!any_pending) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                O_INT_VECTOR = vec_q;
                if (!I_INT_ACK) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLOCK) begin
        if (!I_RESET_L) begin
            if_q        <= '0;
            ie_q        <= '0;
            prev_q      <= '0;
            vec_q       <= '0;
            ack_block_q <= 1'b1;
            state_q     <= ST_IDLE;
        end else begin
            if_q        <= if_d;
            ie_q        <= ie_d;
            prev_q      <= src;
            vec_q       <= vec_d;
            ack_block_q <= ack_block_d;
            state_q     <= state_d;
        end
    end

    assign O_IF_DATA = {3'b111, if_q};
    assign O_IE_DATA = ie_q;
    assign rd_data   = sel_if ? O_IF_DATA : ie_q;
    assign IO_DATA   = (~I_RE_L & (sel_if | sel_ie)) ? rd_data : 8'hzz;

endmodule
